// File: rtl/mod_mul_acc_pipe.sv
// mod_mul_acc_pipe: lane-parallel (a*b + c) mod q with a per-lane accumulator.
// Three pipeline stages behind a valid/ready handshake. A single global enable
// advances or freezes the whole pipe.
module mod_mul_acc_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 16,
  parameter int Q0         = 3329,
  parameter int Q1         = 12289
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] in1_i,
  input  logic [DATA_WIDTH-1:0] in2_i,
  input  logic [DATA_WIDTH-1:0] in3_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int LW    = LANE_WIDTH;
  localparam int XW    = 2 * LW + 1;   // a*b + c
  localparam int K     = 2 * LW;       // 2^K exceeds the largest a*b + c

  localparam logic [K-1:0]  MU0 = K'((64'd1 << K) / 64'(Q0));
  localparam logic [K-1:0]  MU1 = K'((64'd1 << K) / 64'(Q1));
  localparam logic [LW-1:0] QV0 = LW'(Q0);
  localparam logic [LW-1:0] QV1 = LW'(Q1);

  typedef enum logic [1:0] {
    OP_MAC     = 2'b00,
    OP_MACC    = 2'b01,
    OP_LDACC   = 2'b10,
    OP_MAC_ALT = 2'b11
  } op_e;

  logic en;

  // stage 1 registers
  logic          v1;
  op_e           op1;
  logic          m1;
  logic [XW-1:0] x1 [LANES];

  // stage 2 registers
  logic          v2;
  op_e           op2;
  logic          m2;
  logic [LW:0]   r2 [LANES];

  // persistent accumulators
  logic [LW-1:0] acc [LANES];

  // combinational next-stage values
  logic [XW-1:0]         x_d    [LANES];
  logic [XW-1:0]         qhat_d [LANES];
  logic [LW:0]           r_d    [LANES];
  logic [LW:0]           t3     [LANES];
  logic [LW:0]           s3     [LANES];
  logic [LW-1:0]         res_d  [LANES];
  logic [LW-1:0]         acc_d  [LANES];
  logic [DATA_WIDTH-1:0] res_pack;
  logic [K-1:0]          mu2;
  logic [LW-1:0]         q2;
  logic [LW-1:0]         q3;

  assign en         = !(out_valid_o && !out_ready_i);
  assign in_ready_o = en;

  // S1: per-lane multiply and add of the packed operands
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      x_d[i] = XW'(in1_i[i*LW +: LW]) * XW'(in2_i[i*LW +: LW])
             + XW'(in3_i[i*LW +: LW]);
    end
  end

  // S2: Barrett quotient estimate and partial remainder x - qhat*q.
  // The remainder is below 3q < 2^(LW+1), so only the low LW+1 bits are kept.
  always_comb begin
    mu2 = m1 ? MU1 : MU0;
    q2  = m1 ? QV1 : QV0;
    for (int unsigned i = 0; i < LANES; i++) begin
      qhat_d[i] = XW'(({{K{1'b0}}, x1[i]} * {{XW{1'b0}}, mu2}) >> K);
      r_d[i]    = x1[i][LW:0] - (LW+1)'(qhat_d[i] * XW'(q2));
    end
  end

  // S3: final correction, accumulator update and per-op result selection
  always_comb begin
    q3       = m2 ? QV1 : QV0;
    res_pack = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      t3[i] = r2[i];
      if (t3[i] >= {1'b0, q3}) t3[i] = t3[i] - {1'b0, q3};
      if (t3[i] >= {1'b0, q3}) t3[i] = t3[i] - {1'b0, q3};
      s3[i] = {1'b0, acc[i]} + {1'b0, t3[i][LW-1:0]};
      if (s3[i] >= {1'b0, q3}) s3[i] = s3[i] - {1'b0, q3};
      acc_d[i] = acc[i];
      res_d[i] = t3[i][LW-1:0];
      case (op2)
        OP_MACC: begin
          acc_d[i] = s3[i][LW-1:0];
          res_d[i] = s3[i][LW-1:0];
        end
        OP_LDACC: acc_d[i] = t3[i][LW-1:0];
        default:  ;
      endcase
      res_pack[i*LW +: LW] = res_d[i];
    end
  end

  // pipeline registers; everything holds while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_o <= 1'b0;
      op1         <= OP_MAC;
      op2         <= OP_MAC;
      m1          <= 1'b0;
      m2          <= 1'b0;
      result_o    <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        x1[i]  <= '0;
        r2[i]  <= '0;
        acc[i] <= '0;
      end
    end else if (en) begin
      v1          <= in_valid_i;
      op1         <= op_e'(op_i);
      m1          <= mode_i;
      v2          <= v1;
      op2         <= op1;
      m2          <= m1;
      out_valid_o <= v2;
      for (int unsigned i = 0; i < LANES; i++) begin
        x1[i] <= x_d[i];
        r2[i] <= r_d[i];
      end
      if (v2) begin
        result_o <= res_pack;
        for (int unsigned i = 0; i < LANES; i++) acc[i] <= acc_d[i];
      end
    end
  end

endmodule

// File: doc/mod_mul_acc_pipe.md
# mod_mul_acc_pipe

Pipelined, parametrised lane-parallel modular multiply-accumulate unit for the PQ accelerator datapath: per lane computes (a·b + c) mod q, with q selectable per transaction between the Kyber and NewHope moduli. It also offers a persistent per-lane accumulator for dot-product style sequences. It succeeds the combinational single-word modular MAC. It sits between the core's operand path and write-back behind a valid/ready handshake with a fixed 3-cycle latency.

## Interface
- DATA_WIDTH, 32, width of packed operand/result words
- LANE_WIDTH, 16, width of one lane; DATA_WIDTH must be a multiple of LANE_WIDTH (LANES = DATA_WIDTH/LANE_WIDTH, derived)
- Q0, 3329, modulus selected by mode_i = 0
- Q1, 12289, modulus selected by mode_i = 1; both moduli < 2^(LANE_WIDTH-1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid_i  input  1  transaction offered
- in_ready_o  output  1  transaction accepted when in_valid_i && in_ready_o
- op_i  input  2  00 MAC, 01 MACC (add into accumulator), 10 LDACC (load accumulator), 11 treated as MAC
- mode_i  input  1  modulus select (0: Q0, 1: Q1)
- in1_i, in2_i, in3_i  input  DATA_WIDTH  packed lanes a, b, c; lane i = bits [i·LANE_WIDTH +: LANE_WIDTH]
- out_valid_o  output  1  result valid
- out_ready_i  input  1  downstream accepts result
- result_o  output  DATA_WIDTH  packed lane results, zero-extended from reduced value

## Operation
- Per lane, r = (a·b + c) mod q, exact for all unsigned lane inputs 0..2^LANE_WIDTH−1 (inputs ≥ q allowed). Intermediate x = a·b + c is 2·LANE_WIDTH+1 bits.
- Reduction is Barrett with constant mu = floor(2^k / q) per modulus (k chosen so 2^k > max x), computed as localparams. No divider. At most two conditional subtracts of q after the quotient estimate.
- MAC: lane result = r; accumulator unchanged.
- LDACC: acc_lane ← r; lane result = r.
- MACC: acc_lane ← (acc_lane + r), minus q if ≥ q; lane result = new acc_lane.
- Accumulator: LANES registers of LANE_WIDTH bits, updated only when the owning transaction leaves stage 3. MACC requires acc_lane < q of its mode. Software issues LDACC after any mode change; MACC across a mode change without LDACC is undefined but must not corrupt other lanes or the pipeline.
- Stages:
  - S1: per-lane multiply + add, register x.
  - S2: Barrett quotient estimate and x − q̂·q, register.
  - S3: conditional subtracts, accumulator add/subtract, register result_o.
  - op and mode are carried with each stage.

## Timing
- Reset: out_valid_o = 0, result_o = 0, all stage valids = 0, all accumulators = 0. in_ready_o = 1 in the cycle after rst is sampled high.
- A reset asserted mid-operation discards all in-flight transactions and clears the accumulators in that same edge.
- Global advance enable en = !(out_valid_o && !out_ready_i). All stages move together when en = 1 and hold when en = 0.
- in_ready_o = en (combinational).
- Latency: accepted in cycle N → out_valid_o = 1 with its result in cycle N+3 when no stall.
- Throughput: one transaction per cycle.
- Bubbles propagate as invalid stages. Bubbles are not collapsed.
- Stall: while out_valid_o && !out_ready_i, result_o and all stage contents are stable.
- Accumulator ordering: back-to-back MACCs need no interlock, because the accumulator lives in S3 and is read/written in transaction order.
- Simultaneous accept and output handshake in the same cycle is legal and loses no data.

## Test plan
- Reset then single MAC, mode 0, lane0 a=1000 b=2000 c=5 and lane1 a=b=c=3328 → 3 cycles later result_o = {16'd0, 16'd2605}, out_valid_o=1 for one cycle with out_ready_i=1.
- Unreduced inputs, mode 0, lane0 a=b=c=0xFFFF → lane0 = 2397 (0x095D). Mode 1, lane1 a=b=12288, c=0 → lane1 = 1.
- Accumulate, mode 0, lane0 a=1000 b=2000 c=0:
  - LDACC → 2600
  - MACC → 1871
  - MACC → 1142
  - issued back-to-back, outputs in 3 consecutive cycles.
- Backpressure: stream 6 MACs, hold out_ready_i=0 for 4 cycles after first out_valid_o → in_ready_o=0 during stall, result_o stable, all 6 results delivered in order, none dropped or duplicated.
- Reset mid-stream: 2 transactions in flight plus accumulator = 2600, assert rst one cycle → no out_valid_o afterwards; next MACC with a=1000 b=2000 c=0 returns 2600 (accumulator was 0).
- Random: 10k transactions, random ops/modes/operands/ready, with LDACC on each mode change, compared against a reference model.
